// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives word requests to instruction memory and buffers
// the returned words with their PCs for decode, with redirect flush support.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
    logic                  r_drop;
    logic                  w_drop_next;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_req_valid;
    logic w_req_hs;
    logic w_rsp_take;
    logic w_push;
    logic w_pop;
    logic w_instr_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request eligibility uses only the registered count, so decode's ready never reaches imem_req_valid.
    assign w_req_valid   = (r_state == S_REQ) && (r_count < CNT_W'(FIFO_DEPTH));
    assign w_req_hs      = w_req_valid && imem_req_ready;
    assign w_rsp_take    = (r_state == S_WAIT) && imem_rsp_valid;
    assign w_push        = w_rsp_take && !r_drop && !redirect_valid;
    assign w_instr_valid = (r_count != '0);
    assign w_pop         = w_instr_valid && instr_ready;

    always_comb begin
        w_state_next    = r_state;
        w_drop_next     = r_drop;
        w_fetch_pc_next = r_fetch_pc;
        case (r_state)
            S_IDLE: w_state_next = S_REQ;
            S_REQ: begin
                if (w_req_hs) begin
                    w_state_next    = S_WAIT;
                    w_fetch_pc_next = r_fetch_pc + ADDR_WIDTH'(4);
                    // A redirect during the handshake makes the issued request stale.
                    w_drop_next     = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_next = S_REQ;
                    w_drop_next  = 1'b0;
                end else if (redirect_valid) begin
                    w_drop_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (redirect_valid) begin
            w_fetch_pc_next = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_drop     <= w_drop_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rsp_data;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc - ADDR_WIDTH'(4);
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_fetch_pc;
    assign instr_valid    = w_instr_valid;
    assign instruction    = w_instr_valid ? r_mem_data[r_rd_ptr] : '0;
    assign instr_pc       = w_instr_valid ? r_mem_pc[r_rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle-by-cycle vector table on a 32-bit
// instance plus a hand-written address-wrap sequence on an 8-bit instance.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance, RESET_PC = 0x100
    logic        rst, req_ready, rsp_valid, redirect_valid, instr_ready;
    logic [31:0] rsp_data, redirect_pc;
    logic        req_valid, instr_valid;
    logic [31:0] addr, instruction, instr_pc;

    instr_fetch_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    // 8-bit address instance for wrap-around, RESET_PC = 0xFC
    logic        w_rst, w_req_ready, w_rsp_valid, w_redirect_valid, w_instr_ready;
    logic [31:0] w_rsp_data;
    logic [7:0]  w_redirect_pc;
    logic        w_req_valid, w_instr_valid;
    logic [7:0]  w_addr, w_instr_pc;
    logic [31:0] w_instruction;

    instr_fetch_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(8'hFC), .FIFO_DEPTH(2)
    ) dut_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .instruction(w_instruction), .instr_pc(w_instr_pc)
    );

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        redir;
        logic [31:0] rpc;
        logic        ir;
        logic        chk;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(
        input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
        input logic redir, input logic [31:0] rpc, input logic ir, input logic chk,
        input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
        input logic [31:0] e_ins, input logic [31:0] e_pc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rsp_v = rv; v.rsp_d = rd;
        v.redir = redir; v.rpc = rpc; v.ir = ir; v.chk = chk;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ins = e_ins; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic wrap_step(
        input string name, input logic r, input logic rdy, input logic rv,
        input logic [31:0] rd, input logic e_rv, input logic [7:0] e_addr,
        input logic e_iv, input logic [31:0] e_ins, input logic [7:0] e_pc);
        @(negedge clk);
        w_rst = r; w_req_ready = rdy; w_rsp_valid = rv; w_rsp_data = rd;
        #1;
        n_tests++;
        if (w_req_valid !== e_rv || w_addr !== e_addr || w_instr_valid !== e_iv ||
            w_instruction !== e_ins || w_instr_pc !== e_pc) begin
            n_fail++;
            $display("FAIL %s: got rv=%0b addr=%h iv=%0b ins=%h pc=%h, want rv=%0b addr=%h iv=%0b ins=%h pc=%h",
                     name, w_req_valid, w_addr, w_instr_valid, w_instruction, w_instr_pc,
                     e_rv, e_addr, e_iv, e_ins, e_pc);
        end else begin
            $display("[TB] %s ok: rv=%0b addr=%h iv=%0b ins=%h pc=%h",
                     name, w_req_valid, w_addr, w_instr_valid, w_instruction, w_instr_pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //              rst rdy rv rsp_d        rd rpc       ir chk rv addr       iv ins          pc
        vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,        32'h0);
        vecs[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,   0, 1, 0, 32'h100, 0, 32'h0,        32'h0);
        vecs[2]  = mk(1, 0, 0, 32'h0,        0, 32'h0,   0, 1, 0, 32'h100, 0, 32'h0,        32'h0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,   0, 1, 0, 32'h100, 0, 32'h0,        32'h0);
        vecs[4]  = mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 1, 32'h100, 0, 32'h0,        32'h0);
        vecs[5]  = mk(0, 0, 1, 32'h00500093, 0, 32'h0,   0, 1, 0, 32'h104, 0, 32'h0,        32'h0);
        vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,   1, 1, 1, 32'h104, 1, 32'h00500093, 32'h100);
        vecs[7]  = mk(0, 0, 0, 32'h0,        1, 32'h0,   0, 1, 1, 32'h104, 0, 32'h0,        32'h0);
        vecs[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 1, 32'h0,   0, 32'h0,        32'h0);
        vecs[9]  = mk(0, 0, 1, 32'h11111111, 0, 32'h0,   0, 1, 0, 32'h4,   0, 32'h0,        32'h0);
        vecs[10] = mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 1, 32'h4,   1, 32'h11111111, 32'h0);
        vecs[11] = mk(0, 0, 1, 32'h22222222, 0, 32'h0,   0, 1, 0, 32'h8,   1, 32'h11111111, 32'h0);
        vecs[12] = mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 0, 32'h8,   1, 32'h11111111, 32'h0);
        vecs[13] = mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 0, 32'h8,   1, 32'h11111111, 32'h0);
        vecs[14] = mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 0, 32'h8,   1, 32'h11111111, 32'h0);
        vecs[15] = mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 1, 32'h8,   1, 32'h22222222, 32'h4);
        vecs[16] = mk(0, 0, 1, 32'h33333333, 0, 32'h0,   1, 1, 0, 32'hC,   0, 32'h0,        32'h0);
        vecs[17] = mk(0, 1, 0, 32'h0,        1, 32'h203, 1, 1, 1, 32'hC,   1, 32'h33333333, 32'h8);
        vecs[18] = mk(0, 0, 1, 32'hDEADBEEF, 0, 32'h0,   1, 1, 0, 32'h200, 0, 32'h0,        32'h0);
        vecs[19] = mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 1, 32'h200, 0, 32'h0,        32'h0);
        vecs[20] = mk(0, 0, 0, 32'h0,        1, 32'h40,  1, 1, 0, 32'h204, 0, 32'h0,        32'h0);
        vecs[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,   1, 1, 0, 32'h40,  0, 32'h0,        32'h0);
        vecs[22] = mk(0, 0, 1, 32'hBADBAD00, 0, 32'h0,   1, 1, 0, 32'h40,  0, 32'h0,        32'h0);
        vecs[23] = mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 1, 32'h40,  0, 32'h0,        32'h0);
        vecs[24] = mk(0, 0, 1, 32'h44444444, 0, 32'h0,   1, 1, 0, 32'h44,  0, 32'h0,        32'h0);
        vecs[25] = mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 1, 32'h44,  1, 32'h44444444, 32'h40);
        vecs[26] = mk(0, 0, 1, 32'hCAFEF00D, 1, 32'h80,  1, 1, 0, 32'h48,  0, 32'h0,        32'h0);
        vecs[27] = mk(0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 1, 32'h80,  0, 32'h0,        32'h0);
        vecs[28] = mk(0, 0, 1, 32'h55555555, 0, 32'h0,   0, 1, 0, 32'h84,  0, 32'h0,        32'h0);
        vecs[29] = mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 1, 32'h84,  1, 32'h55555555, 32'h80);
        vecs[30] = mk(1, 0, 0, 32'h0,        0, 32'h0,   0, 1, 0, 32'h88,  1, 32'h55555555, 32'h80);
        vecs[31] = mk(0, 0, 1, 32'h77777777, 0, 32'h0,   0, 1, 0, 32'h100, 0, 32'h0,        32'h0);
        vecs[32] = mk(0, 0, 1, 32'h77777777, 0, 32'h0,   0, 1, 1, 32'h100, 0, 32'h0,        32'h0);
        vecs[33] = mk(0, 0, 0, 32'h0,        0, 32'h0,   0, 1, 1, 32'h100, 0, 32'h0,        32'h0);

        rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        w_rst = 1'b1; w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_instr_ready = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; req_ready = vecs[i].rdy;
            rsp_valid = vecs[i].rsp_v; rsp_data = vecs[i].rsp_d;
            redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            instr_ready = vecs[i].ir;
            #1;
            if (vecs[i].chk) begin
                n_tests++;
                if (req_valid !== vecs[i].e_rv || addr !== vecs[i].e_addr ||
                    instr_valid !== vecs[i].e_iv || instruction !== vecs[i].e_ins ||
                    instr_pc !== vecs[i].e_pc) begin
                    n_fail++;
                    $display("FAIL vec%0d: got rv=%0b addr=%h iv=%0b ins=%h pc=%h, want rv=%0b addr=%h iv=%0b ins=%h pc=%h",
                             i, req_valid, addr, instr_valid, instruction, instr_pc,
                             vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_ins, vecs[i].e_pc);
                end else begin
                    $display("[TB] vec%0d ok: rv=%0b addr=%h iv=%0b ins=%h pc=%h",
                             i, req_valid, addr, instr_valid, instruction, instr_pc);
                end
            end
        end

        // Address wrap on the 8-bit instance: fetch at 0xFC, next address 0x00.
        wrap_step("wrap_reset", 1, 0, 0, 32'h0,        0, 8'hFC, 0, 32'h0,        8'h00);
        wrap_step("wrap_idle",  0, 0, 0, 32'h0,        0, 8'hFC, 0, 32'h0,        8'h00);
        wrap_step("wrap_req",   0, 1, 0, 32'h0,        1, 8'hFC, 0, 32'h0,        8'h00);
        wrap_step("wrap_wait",  0, 0, 1, 32'hA5A5A5A5, 0, 8'h00, 0, 32'h0,        8'h00);
        wrap_step("wrap_head",  0, 0, 0, 32'h0,        1, 8'h00, 1, 32'hA5A5A5A5, 8'hFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
